ram_burst_ctrl: RTL and testbench



---
 rtl/ram_burst_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst sequencer in front of a byte-wide synchronous RAM.
//               Accepts one write or read burst command at a time, streams
//               write bytes into the RAM and read bytes out through a
//               2-entry buffer that absorbs the one-cycle RAM read latency
//               and consumer backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_burst_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // write data channel
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    // read data channel
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    // status
    output logic              busy,
    // RAM side
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_read  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        c_cnt_one  = 2'd1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LEN_W-1:0]  remain_q,   remain_d;    // beats left minus one
    logic              inflight_q, inflight_d;  // read issued last cycle
    logic [DATA_W-1:0] fifo0_q,    fifo0_d;
    logic [DATA_W-1:0] fifo1_q,    fifo1_d;
    logic              rd_ptr_q,   rd_ptr_d;
    logic              wr_ptr_q,   wr_ptr_d;
    logic [1:0]        count_q,    count_d;     // buffered bytes (0..2)

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_wr_beat;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_last;
    logic [DATA_W-1:0] w_head;

    // Handshake, credit and beat qualification.
    // Credit counts buffered bytes plus the one possibly in flight; a byte
    // leaving this cycle frees a slot, so issue is allowed while the
    // occupancy after the pop stays below the buffer depth.
    always_comb begin
        w_wr_beat = (state_q == c_st_write) && wr_valid;
        w_push    = inflight_q;
        w_pop     = (count_q != 2'd0) && rd_ready;
        w_occ     = {1'b0, count_q} + {2'b00, inflight_q};
        w_credit  = w_occ < (3'd2 + {2'b00, w_pop});
        w_issue   = (state_q == c_st_read) && w_credit;
        w_last    = (remain_q == '0);
        w_head    = rd_ptr_q ? fifo1_q : fifo0_q;
    end

    // Output decode; all outputs are quiet (zero) outside their own state.
    always_comb begin
        cmd_ready   = (state_q == c_st_idle);
        busy        = (state_q != c_st_idle);
        wr_ready    = (state_q == c_st_write);
        ram_we      = w_wr_beat;
        ram_data_in = w_wr_beat ? wr_data : '0;
        ram_address = ((state_q == c_st_write) || (state_q == c_st_read)) ? addr_q : '0;
        rd_valid    = (count_q != 2'd0);
        rd_data     = (count_q != 2'd0) ? w_head : '0;
    end

    // Burst sequencing: command latch, address walk and beat countdown.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        inflight_d = w_issue;

        case (state_q)
            c_st_idle: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    state_d  = cmd_write ? c_st_write : c_st_read;
                end
            end
            c_st_write: begin
                if (w_wr_beat) begin
                    // address wraps naturally at the top of the array
                    addr_d   = addr_q + c_addr_one;
                    remain_d = remain_q - c_len_one;
                    if (w_last) begin
                        state_d = c_st_idle;
                    end
                end
            end
            c_st_read: begin
                if (w_issue) begin
                    addr_d   = addr_q + c_addr_one;
                    remain_d = remain_q - c_len_one;
                    if (w_last) begin
                        state_d = c_st_drain;
                    end
                end
            end
            c_st_drain: begin
                // the last in-flight byte must land and be consumed first
                if (!inflight_q && (count_q == 2'd0)) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Read buffer: RAM byte returned one cycle after issue is pushed,
    // head byte is popped on the consumer handshake; both may coincide.
    always_comb begin
        fifo0_d  = fifo0_q;
        fifo1_d  = fifo1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (w_push) begin
            if (wr_ptr_q) begin
                fifo1_d = ram_data_out;
            end else begin
                fifo0_d = ram_data_out;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset aborts any burst and discards buffered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_st_idle;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Scoreboard bench for ram_burst_ctrl with a synchronous
//               byte RAM model; directed write/read bursts, address wrap,
//               write gaps, random read backpressure and mid-burst reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_burst_ctrl;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    ram_burst_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .busy        (busy),
        .ram_we      (ram_we),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: write on we, registered read data.
    logic [7:0] ram_mem [0:32767];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    // Bench-side shadow of what has been written, and scoreboards.
    logic [7:0]  model [0:32767];
    logic [22:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    int n_vec = 0;
    int n_err = 0;
    int n_we  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes RAM or hands out a byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("we_during_reset", {31'd0, ram_we}, 32'd0);
        end else begin
            if (ram_we) begin
                n_we++;
                if (exp_wr.size() == 0) begin
                    check("ram_wr_unexpected", {9'd0, ram_address, ram_data_in}, 32'hFFFF_FFFF);
                end else begin
                    check("ram_wr_addr_data", {9'd0, ram_address, ram_data_in},
                          {9'd0, exp_wr.pop_front()});
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", {24'd0, rd_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
                end
            end
        end
    end

    // Present a command from #1 after an edge; returns #1 after acceptance edge.
    task automatic send_cmd(input logic w, input logic [14:0] a, input logic [7:0] l);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = ~w;            // junk outside IDLE must be ignored
        cmd_addr  = 15'h5555;
        cmd_len   = 8'hFF;
    endtask

    task automatic do_write(input logic [14:0] addr, input logic [7:0] len,
                            input logic [7:0] d0, input bit gap, input bit chk_time);
        logic [14:0] a;
        logic [7:0]  d;
        int          cyc;
        int          we0;
        int          n;
        we0 = n_we;
        cyc = 0;
        send_cmd(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 15'(i);
            d = d0 + 8'(i);
            exp_wr.push_back({a, d});
            model[a] = d;
            wr_valid = 1'b1;
            wr_data  = d;
            n = 0;
            @(negedge clk);
            while (!wr_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!wr_ready) check("wr_ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            cyc++;
            wr_valid = 1'b0;
            wr_data  = 8'h00;
            if (gap && i != int'(len)) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(negedge clk);
        check("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("wr_done_busy", {31'd0, busy}, 32'd0);
        check("wr_we_pulses", 32'(n_we - we0), 32'(int'(len) + 1));
        if (chk_time) check("wr_burst_cycles", 32'(cyc), 32'(int'(len) + 1));
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [14:0] addr, input logic [7:0] len,
                           input bit rnd, input bit chk_lat);
        logic [14:0] a;
        int k;
        int first;
        int last;
        int pops;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 15'(i);
            exp_rd.push_back(model[a]);
        end
        rd_ready = 1'b1;
        send_cmd(1'b0, addr, len);
        k = 0; first = -1; last = -1; pops = 0;
        while (k < 3000) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (first < 0) first = k;
                last = k;
                pops++;
            end
            if (cmd_ready && exp_rd.size() == 0) break;
            @(posedge clk); #1;
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        check("rd_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rd_byte_count", 32'(pops), 32'(int'(len) + 1));
        if (chk_lat) begin
            check("rd_first_latency", 32'(first), 32'd2);
            check("rd_last_beat", 32'(last), 32'(2 + int'(len)));
        end
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
        check("rst_busy",        {31'd0, busy},        32'd0);
        check("rst_wr_ready",    {31'd0, wr_ready},    32'd0);
        check("rst_rd_valid",    {31'd0, rd_valid},    32'd0);
        check("rst_ram_address", {17'd0, ram_address}, 32'd0);
        check("rst_ram_data_in", {24'd0, ram_data_in}, 32'd0);
        check("rst_rd_data",     {24'd0, rd_data},     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic write then read-back with latency checks
        do_write(15'h0010, 8'd3, 8'hA0, 1'b0, 1'b1);
        do_read (15'h0010, 8'd3, 1'b0, 1'b1);

        // address wrap at the top of the array
        do_write(15'h7FFE, 8'd3, 8'hC0, 1'b0, 1'b1);
        do_read (15'h7FFE, 8'd3, 1'b0, 1'b1);

        // write with wr_valid low on alternate cycles
        do_write(15'h0100, 8'd5, 8'h30, 1'b1, 1'b0);
        do_read (15'h0100, 8'd5, 1'b0, 1'b1);

        // full-length burst read under random backpressure
        do_write(15'h0400, 8'd255, 8'h17, 1'b0, 1'b1);
        do_read (15'h0400, 8'd255, 1'b1, 1'b0);

        // reset after two beats of an 8-beat write
        do_write(15'h0200, 8'd7, 8'hE0, 1'b0, 1'b1);
        send_cmd(1'b1, 15'h0200, 8'd7);
        wr_valid = 1'b1;
        wr_data  = 8'h50;
        exp_wr.push_back({15'h0200, 8'h50});
        model[15'h0200] = 8'h50;
        @(posedge clk); #1;
        wr_data  = 8'h51;
        exp_wr.push_back({15'h0201, 8'h51});
        model[15'h0201] = 8'h51;
        @(posedge clk); #1;
        rst_n   = 1'b0;
        wr_data = 8'h52;
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_busy",      {31'd0, busy},      32'd0);
        check("post_rst_rd_valid",  {31'd0, rd_valid},  32'd0);
        @(posedge clk); #1;
        do_read(15'h0200, 8'd7, 1'b0, 1'b1);

        // every expectation consumed
        check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        check("exp_rd_left", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
